// File: rtl/alu_ctrl_decoder_if.sv
// Decoder <-> fetch/ALU bundle: instruction handshake, flags in,
// registered execute controls out (master = decoder side).
interface alu_ctrl_decoder_if;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       Z, N, C, V;
  logic [3:0] alu_op;
  logic [1:0] ra_sel, rb_sel;
  logic       reg_we;
  logic [1:0] wb_dst;
  logic       wb_mem;
  logic       mem_rd, mem_wr;
  logic [1:0] sp_op;
  logic [7:0] imm;
  logic       imm_valid;
  logic       out_en, in_en;
  logic       pc_load, pc_src;
  logic       flush;
  logic [3:0] flag_clr;
  logic       halted;

  modport master (
    input  instr, instr_valid, Z, N, C, V,
    output instr_ready, alu_op, ra_sel, rb_sel,
    output reg_we, wb_dst, wb_mem, mem_rd, mem_wr,
    output sp_op, imm, imm_valid, out_en, in_en,
    output pc_load, pc_src, flush, flag_clr, halted
  );

  modport slave (
    output instr, instr_valid, Z, N, C, V,
    input  instr_ready, alu_op, ra_sel, rb_sel,
    input  reg_we, wb_dst, wb_mem, mem_rd, mem_wr,
    input  sp_op, imm, imm_valid, out_en, in_en,
    input  pc_load, pc_src, flush, flag_clr, halted
  );
endinterface

// File: rtl/alu_ctrl_decoder.sv
// Decode stage: instr byte + flags in (bus), registered ALU/mem/stack/
// I/O/PC controls out (bus); clk, async active-low rst.
module alu_ctrl_decoder #(
  parameter logic [3:0] RESET_NOP_OP = 4'h0
) (
  input  logic clk,
  input  logic rst,
  alu_ctrl_decoder_if.master bus
);

  typedef enum logic [1:0] {
    DEC, IMM, RET2, HALT
  } state_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [1:0] ra_sel;
    logic [1:0] rb_sel;
    logic       reg_we;
    logic [1:0] wb_dst;
    logic       wb_mem;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] sp_op;
    logic [7:0] imm;
    logic       imm_valid;
    logic       out_en;
    logic       in_en;
    logic       pc_load;
    logic       pc_src;
    logic       flush;
    logic [3:0] flag_clr;
    logic       halted;
  } ctl_t;

  localparam ctl_t NOP = '{
    alu_op: RESET_NOP_OP,
    default: '0
  };

  state_t     st, st_n;
  ctl_t       q, n;
  logic [1:0] pend_op, pend_op_n;
  logic [1:0] pend_rb, pend_rb_n;
  logic       rdy;
  logic       acc;
  logic [3:0] op;
  logic [1:0] ra, rb;
  logic [3:0] flags;

  assign op    = bus.instr[7:4];
  assign ra    = bus.instr[3:2];
  assign rb    = bus.instr[1:0];
  assign flags = {bus.V, bus.C, bus.N, bus.Z};

  // rdy holds ready low until the first clock after reset release
  assign bus.instr_ready = rdy & ((st == DEC) | (st == IMM));
  assign acc = bus.instr_valid & bus.instr_ready;

  always_comb begin
    n         = NOP;
    st_n      = st;
    pend_op_n = pend_op;
    pend_rb_n = pend_rb;
    unique case (st)
      DEC: begin
        // q.flush high: this byte is the stale fetch, drop it
        if (acc && !q.flush) begin
          unique case (op)
            4'h0, 4'hE: ;
            4'h1: begin
              n.alu_op = 4'h0;
              n.rb_sel = rb;
              n.reg_we = 1'b1;
              n.wb_dst = ra;
            end
            4'h2, 4'h3, 4'h4, 4'h5: begin
              n.alu_op = op - 4'h1;
              n.ra_sel = ra;
              n.rb_sel = rb;
              n.reg_we = 1'b1;
              n.wb_dst = ra;
            end
            4'h6: begin
              n.rb_sel = rb;
              n.reg_we = 1'b1;
              n.wb_dst = rb;
              unique case (ra)
                2'd0: n.alu_op = 4'h5;
                2'd1: n.alu_op = 4'h6;
                2'd2: n.alu_op = 4'h9;
                2'd3: n.alu_op = 4'hA;
                default: ;
              endcase
            end
            4'h7: begin
              unique case (ra)
                2'd0: begin
                  n.alu_op = 4'hC;
                  n.rb_sel = rb;
                  n.reg_we = 1'b1;
                  n.wb_dst = rb;
                end
                2'd1: begin
                  n.alu_op = 4'hB;
                  n.rb_sel = rb;
                  n.reg_we = 1'b1;
                  n.wb_dst = rb;
                end
                2'd2: n.alu_op = 4'h7;
                2'd3: n.alu_op = 4'h8;
                default: ;
              endcase
            end
            4'h8: begin
              unique case (ra)
                2'd0: begin
                  n.rb_sel = rb;
                  n.mem_wr = 1'b1;
                  n.sp_op  = 2'b01;
                end
                2'd1: begin
                  n.mem_rd = 1'b1;
                  n.sp_op  = 2'b10;
                  n.reg_we = 1'b1;
                  n.wb_mem = 1'b1;
                  n.wb_dst = rb;
                end
                2'd2: begin
                  n.rb_sel = rb;
                  n.out_en = 1'b1;
                end
                2'd3: begin
                  n.in_en  = 1'b1;
                  n.reg_we = 1'b1;
                  n.wb_dst = rb;
                end
                default: ;
              endcase
            end
            4'h9: begin
              if (flags[ra]) begin
                n.rb_sel       = rb;
                n.pc_load      = 1'b1;
                n.flush        = 1'b1;
                n.flag_clr[ra] = 1'b1;
              end
            end
            4'hA: begin
              unique case (ra)
                2'd0: begin
                  n.rb_sel  = rb;
                  n.pc_load = 1'b1;
                  n.flush   = 1'b1;
                end
                2'd1: begin
                  n.rb_sel  = rb;
                  n.mem_wr  = 1'b1;
                  n.sp_op   = 2'b01;
                  n.pc_load = 1'b1;
                  n.flush   = 1'b1;
                end
                2'd2, 2'd3: begin
                  n.mem_rd = 1'b1;
                  n.sp_op  = 2'b10;
                  st_n     = RET2;
                end
                default: ;
              endcase
            end
            4'hB, 4'hC, 4'hD: begin
              pend_op_n = op[1:0];
              pend_rb_n = rb;
              st_n      = IMM;
            end
            4'hF: begin
              n.halted = 1'b1;
              st_n     = HALT;
            end
            default: ;
          endcase
        end
      end
      IMM: begin
        if (acc) begin
          n.imm       = bus.instr;
          n.imm_valid = 1'b1;
          st_n        = DEC;
          // pend_op is opcode[1:0]: B=11 LDM, C=00 LDD, D=01 STD
          unique case (pend_op)
            2'b11: begin
              n.alu_op = 4'hE;
              n.reg_we = 1'b1;
              n.wb_dst = pend_rb;
            end
            2'b00: begin
              n.mem_rd = 1'b1;
              n.wb_mem = 1'b1;
              n.reg_we = 1'b1;
              n.wb_dst = pend_rb;
            end
            2'b01: begin
              n.rb_sel = pend_rb;
              n.mem_wr = 1'b1;
            end
            default: ;
          endcase
        end
      end
      RET2: begin
        n.pc_load = 1'b1;
        n.pc_src  = 1'b1;
        n.flush   = 1'b1;
        st_n      = DEC;
      end
      HALT: n.halted = 1'b1;
      default: st_n = DEC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= DEC;
      q       <= NOP;
      pend_op <= 2'b00;
      pend_rb <= 2'b00;
      rdy     <= 1'b0;
    end else begin
      st      <= st_n;
      q       <= n;
      pend_op <= pend_op_n;
      pend_rb <= pend_rb_n;
      rdy     <= 1'b1;
    end
  end

  assign bus.alu_op    = q.alu_op;
  assign bus.ra_sel    = q.ra_sel;
  assign bus.rb_sel    = q.rb_sel;
  assign bus.reg_we    = q.reg_we;
  assign bus.wb_dst    = q.wb_dst;
  assign bus.wb_mem    = q.wb_mem;
  assign bus.mem_rd    = q.mem_rd;
  assign bus.mem_wr    = q.mem_wr;
  assign bus.sp_op     = q.sp_op;
  assign bus.imm       = q.imm;
  assign bus.imm_valid = q.imm_valid;
  assign bus.out_en    = q.out_en;
  assign bus.in_en     = q.in_en;
  assign bus.pc_load   = q.pc_load;
  assign bus.pc_src    = q.pc_src;
  assign bus.flush     = q.flush;
  assign bus.flag_clr  = q.flag_clr;
  assign bus.halted    = q.halted;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Directed bench for alu_ctrl_decoder: reset, ALU ops, jumps,
// immediates, RET, stack/CALL and halt.
module tb_alu_ctrl_decoder;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  logic [63:0] got, exp;

  alu_ctrl_decoder_if bus ();

  alu_ctrl_decoder #(.RESET_NOP_OP(4'h0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] all_out();
    return {bus.alu_op, bus.ra_sel, bus.rb_sel,
            bus.reg_we, bus.wb_dst, bus.wb_mem,
            bus.mem_rd, bus.mem_wr, bus.sp_op,
            bus.imm, bus.imm_valid, bus.out_en,
            bus.in_en, bus.pc_load, bus.pc_src,
            bus.flush, bus.flag_clr, bus.halted};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    bus.instr = b;
    bus.instr_valid = 1'b1;
  endtask

  task automatic idle();
    bus.instr_valid = 1'b0;
    bus.instr = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    put(8'h26);
    tick();
    rst = 1'b0;
    idle();
    #1;
    got = {all_out(), bus.instr_ready};
    exp = 0;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL rst_outs got=%h exp=%h", got, exp);
    end
    rst = 1'b1;
    #1;
    got = bus.instr_ready;
    exp = 0;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL rdy_pre got=%h exp=%h", got, exp);
    end
    tick();
    got = bus.instr_ready;
    exp = 1;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL rdy_post got=%h exp=%h", got, exp);
    end
    put(8'h26);
    tick();
    idle();
    got = {bus.alu_op, bus.ra_sel, bus.rb_sel,
           bus.reg_we, bus.wb_dst};
    exp = {4'h1, 2'd1, 2'd2, 1'b1, 2'd1};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL add got=%h exp=%h", got, exp);
    end
    tick();
    got = all_out();
    exp = 0;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL add_hold got=%h exp=%h", got, exp);
    end
    // reset while waiting for an immediate abandons it
    put(8'hC0);
    tick();
    idle();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    put(8'h5A);
    tick();
    idle();
    got = {bus.alu_op, bus.imm_valid, bus.mem_rd,
           bus.wb_mem, bus.reg_we, bus.wb_dst};
    exp = {4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL rst_imm got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_jump();
    bus.Z = 1'b1;
    put(8'h93);
    tick();
    put(8'h26);
    got = {bus.pc_load, bus.pc_src, bus.flush,
           bus.flag_clr, bus.rb_sel, bus.reg_we};
    exp = {1'b1, 1'b0, 1'b1, 4'b0001, 2'd3, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL jz_taken got=%h exp=%h", got, exp);
    end
    tick();
    got = all_out();
    exp = 0;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL flush_drop got=%h exp=%h", got, exp);
    end
    bus.Z = 1'b0;
    put(8'h93);
    tick();
    got = all_out();
    exp = 0;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL jz_not got=%h exp=%h", got, exp);
    end
    bus.C = 1'b1;
    put(8'h9B);
    tick();
    idle();
    got = {bus.pc_load, bus.flush, bus.flag_clr};
    exp = {1'b1, 1'b1, 4'b0100};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL jc_taken got=%h exp=%h", got, exp);
    end
    bus.C = 1'b0;
    tick();
  endtask

  task automatic test_imm();
    put(8'hB2);
    tick();
    idle();
    got = {all_out(), bus.instr_ready};
    exp = 1;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL imm_wait1 got=%h exp=%h", got, exp);
    end
    bus.Z = 1'b1;
    tick();
    got = all_out();
    exp = 0;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL imm_wait2 got=%h exp=%h", got, exp);
    end
    bus.Z = 1'b0;
    put(8'h5A);
    tick();
    put(8'h26);
    got = {bus.imm, bus.imm_valid, bus.reg_we,
           bus.wb_dst, bus.alu_op, bus.mem_rd,
           bus.mem_wr, bus.wb_mem};
    exp = {8'h5A, 1'b1, 1'b1, 2'd2, 4'hE,
           1'b0, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL ldm got=%h exp=%h", got, exp);
    end
    tick();
    put(8'hD1);
    got = {bus.alu_op, bus.reg_we, bus.imm_valid};
    exp = {4'h1, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL imm_to_dec got=%h exp=%h", got, exp);
    end
    tick();
    put(8'h33);
    tick();
    idle();
    got = {bus.imm, bus.imm_valid, bus.mem_wr,
           bus.rb_sel, bus.reg_we, bus.mem_rd};
    exp = {8'h33, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL std got=%h exp=%h", got, exp);
    end
    tick();
  endtask

  task automatic test_ret();
    put(8'hA8);
    tick();
    put(8'h26);
    got = {bus.mem_rd, bus.sp_op, bus.instr_ready,
           bus.pc_load, bus.flush};
    exp = {1'b1, 2'b10, 1'b0, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL ret1 got=%h exp=%h", got, exp);
    end
    tick();
    got = {bus.pc_load, bus.pc_src, bus.flush,
           bus.mem_rd, bus.sp_op, bus.instr_ready};
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL ret2 got=%h exp=%h", got, exp);
    end
    tick();
    idle();
    got = {all_out(), bus.instr_ready};
    exp = 1;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL ret_after got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    put(8'h71);
    tick();
    put(8'h78);
    got = {bus.alu_op, bus.wb_dst, bus.rb_sel, bus.reg_we};
    exp = {4'hC, 2'd1, 2'd1, 1'b1};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL dec_r1 got=%h exp=%h", got, exp);
    end
    tick();
    put(8'h85);
    got = {bus.alu_op, bus.reg_we};
    exp = {4'h7, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL setc got=%h exp=%h", got, exp);
    end
    tick();
    put(8'hA6);
    got = {bus.mem_rd, bus.sp_op, bus.reg_we,
           bus.wb_mem, bus.wb_dst};
    exp = {1'b1, 2'b10, 1'b1, 1'b1, 2'd1};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL pop got=%h exp=%h", got, exp);
    end
    tick();
    idle();
    got = {bus.mem_wr, bus.sp_op, bus.pc_load,
           bus.pc_src, bus.flush, bus.rb_sel};
    exp = {1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 2'd2};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL call got=%h exp=%h", got, exp);
    end
    tick();
  endtask

  task automatic test_halt();
    put(8'hF0);
    tick();
    put(8'h26);
    got = {bus.halted, bus.instr_ready};
    exp = {1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL hlt got=%h exp=%h", got, exp);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      got = {bus.halted, bus.instr_ready, bus.reg_we};
      exp = {1'b1, 1'b0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL hlt_hold%0d got=%h exp=%h",
                 i, got, exp);
      end
    end
    idle();
    rst = 1'b0;
    #1;
    got = all_out();
    exp = 0;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL hlt_rst got=%h exp=%h", got, exp);
    end
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    bus.Z = 1'b0;
    bus.N = 1'b0;
    bus.C = 1'b0;
    bus.V = 1'b0;
    idle();
    repeat (2) tick();
    test_reset();
    test_jump();
    test_imm();
    test_ret();
    test_back_to_back();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
